// File: rtl/fp_mul_driver_pkg.sv
// Shared types and constants for the single-precision multiplier driver
// and the benches that exercise it.
package fp_mul_driver_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_Z = 2'd2,
        OUT    = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_TAG_W = 4;
    localparam int unsigned DEFAULT_CNT_W = 16;

    localparam logic [31:0] FP_TWO   = 32'h40000000;
    localparam logic [31:0] FP_THREE = 32'h40400000;

endpackage

// File: rtl/fp_mul_driver_if.sv
// Operand/result handshake bundle between the scheduler stream, the driver
// and one multiplier instance. master = driver side, slave = environment.
interface fp_mul_driver_if
    import fp_mul_driver_pkg::*;
#(
    parameter int unsigned TAG_W = DEFAULT_TAG_W
) ();

    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             in_valid;
    logic             in_ready;

    logic [31:0]      mul_a;
    logic             mul_a_stb;
    logic             mul_a_ack;
    logic [31:0]      mul_b;
    logic             mul_b_stb;
    logic             mul_b_ack;
    logic [31:0]      mul_z;
    logic             mul_z_stb;
    logic             mul_z_ack;

    logic [31:0]      out_z;
    logic [TAG_W-1:0] out_tag;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  in_a, in_b, in_tag, in_valid,
        output in_ready,
        output mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack,
        input  mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
        output out_z, out_tag, out_valid,
        input  out_ready
    );

    modport slave (
        output in_a, in_b, in_tag, in_valid,
        input  in_ready,
        input  mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack,
        output mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
        input  out_z, out_tag, out_valid,
        output out_ready
    );

endinterface

// File: rtl/fp_mul_driver_handshake_watchdog.sv
// Saturating cycle counter for stb/ack initiators; hit pulses for one cycle
// on the edge where the count reaches TIMEOUT_CYCLES.
module handshake_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int unsigned    CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // Single-cycle event so a cleared flag is not re-raised while saturated.
    assign hit = en && !clr && (count == LIMIT - 1'b1);

endmodule

// File: rtl/fp_mul_driver.sv
// Initiator for the multiplier's stb/ack operand and result handshake, one
// operation in flight, with a sticky watchdog flag and a completion counter.
module fp_mul_driver
    import fp_mul_driver_pkg::*;
#(
    parameter int unsigned TAG_W          = DEFAULT_TAG_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    fp_mul_driver_if.master    bus,
    input  logic               err_clr,
    output logic               err,
    output logic [CNT_W-1:0]   op_count
);

    state_t           state;
    logic [TAG_W-1:0] tag;
    logic             a_xfer;
    logic             b_xfer;
    logic             wd_clr;
    logic             wd_en;
    logic             wd_hit;

    assign a_xfer       = bus.mul_a_stb && bus.mul_a_ack;
    assign b_xfer       = bus.mul_b_stb && bus.mul_b_ack;
    assign bus.in_ready = (state == IDLE);

    assign wd_clr = (state == IDLE) && bus.in_valid;
    assign wd_en  = (state == SEND) || (state == WAIT_Z);

    handshake_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk(clk),
        .rst(rst),
        .clr(wd_clr),
        .en (wd_en),
        .hit(wd_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            tag           <= '0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
            bus.mul_a_stb <= 1'b0;
            bus.mul_b_stb <= 1'b0;
            bus.mul_z_ack <= 1'b0;
            bus.out_z     <= '0;
            bus.out_tag   <= '0;
            bus.out_valid <= 1'b0;
            op_count      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.mul_a     <= bus.in_a;
                        bus.mul_b     <= bus.in_b;
                        tag           <= bus.in_tag;
                        bus.mul_a_stb <= 1'b1;
                        bus.mul_b_stb <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (a_xfer) bus.mul_a_stb <= 1'b0;
                    if (b_xfer) bus.mul_b_stb <= 1'b0;
                    // An operand is finished once its strobe is low or transfers on this edge.
                    if ((a_xfer || !bus.mul_a_stb) && (b_xfer || !bus.mul_b_stb)) begin
                        bus.mul_z_ack <= 1'b1;
                        state         <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (bus.mul_z_stb && bus.mul_z_ack) begin
                        bus.out_z     <= bus.mul_z;
                        bus.out_tag   <= tag;
                        bus.mul_z_ack <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_valid && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        op_count      <= op_count + 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (wd_hit) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_mul_driver.sv
// Directed bench for fp_mul_driver: table of operations against a behavioural
// multiplier, plus watchdog and mid-operation reset sequences.
module tb_fp_mul_driver;
    import fp_mul_driver_pkg::*;

    localparam int unsigned TAG_W   = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 16;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      z;        // hand-computed product
        int               a_dly;    // SEND cycle in which mul_a_ack rises
        int               b_dly;
        int               z_dly;    // cycles from mul_z_ack seen to mul_z_stb
        int               r_dly;    // cycles out_ready held low after out_valid
        bit               hold;     // keep in_valid high with junk during the op
        int               exp_zack; // SEND cycle in which mul_z_ack first reads 1
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             err_clr;
    logic             err;
    logic [CNT_W-1:0] op_count;
    int unsigned      n_cmp = 0;
    int unsigned      n_bad = 0;
    vec_t             vecs[6];
    logic [CNT_W-1:0] cnt0;

    always #5 clk = ~clk;

    fp_mul_driver_if #(.TAG_W(TAG_W)) bus ();

    fp_mul_driver #(
        .TAG_W(TAG_W),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err_clr(err_clr),
        .err(err),
        .op_count(op_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural single-precision multiply, normal operands, round-to-nearest-even.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] mant;
        logic [23:0] m24;
        logic        g;
        logic        s;
        int          e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            mant = p[46:24]; g = p[23]; s = |p[22:0]; e = e + 1;
        end else begin
            mant = p[45:23]; g = p[22]; s = |p[21:0];
        end
        m24 = {1'b0, mant} + 24'(g && (s || mant[0]));
        if (m24[23]) e = e + 1;
        return {a[31] ^ b[31], 8'(e), m24[22:0]};
    endfunction

    task automatic run_op(input vec_t v);
        int cyc, a_x, b_x, zack_cyc, z_cyc, ov_cyc;
        bit a_done, b_done, z_done, o_done;
        logic [CNT_W-1:0] c0;
        c0 = op_count;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_a = v.a; bus.in_b = v.b; bus.in_tag = v.tag; bus.in_valid = 1'b1;
        step();
        if (v.hold) begin
            bus.in_a = ~v.a; bus.in_b = ~v.b; bus.in_tag = ~v.tag;
        end else begin
            bus.in_valid = 1'b0;
        end
        cyc = 1; a_x = 0; b_x = 0; zack_cyc = -1; z_cyc = -1; ov_cyc = -1;
        a_done = 0; b_done = 0; z_done = 0; o_done = 0;
        while (!o_done && cyc < 200) begin
            bus.mul_a_ack = (cyc >= v.a_dly);
            bus.mul_b_ack = (cyc >= v.b_dly);
            if (zack_cyc < 0 && bus.mul_z_ack) zack_cyc = cyc;
            bus.mul_z_stb = !z_done && zack_cyc >= 0 && cyc >= zack_cyc + v.z_dly;
            bus.mul_z     = bus.mul_z_stb ? fmul(bus.mul_a, bus.mul_b) : 32'hDEADBEEF;
            if (ov_cyc < 0 && bus.out_valid) ov_cyc = cyc;

            check("in_ready_busy", 32'(bus.in_ready), 32'd0);
            check("mul_a_stb", 32'(bus.mul_a_stb), 32'(!a_done));
            check("mul_b_stb", 32'(bus.mul_b_stb), 32'(!b_done));
            check("mul_z_ack", 32'(bus.mul_z_ack), 32'(a_done && b_done && !z_done));
            check("mul_a", bus.mul_a, v.a);
            check("mul_b", bus.mul_b, v.b);
            check("out_valid", 32'(bus.out_valid), 32'(z_done));
            check("op_count_hold", 32'(op_count), 32'(c0));
            check("err_quiet", 32'(err), 32'd0);
            if (z_done) begin
                check("out_z", bus.out_z, v.z);
                check("out_tag", 32'(bus.out_tag), 32'(v.tag));
            end

            bus.out_ready = z_done && (cyc >= z_cyc + 1 + v.r_dly);
            if (bus.mul_a_stb && bus.mul_a_ack) begin a_x++; a_done = 1; end
            if (bus.mul_b_stb && bus.mul_b_ack) begin b_x++; b_done = 1; end
            if (bus.mul_z_stb && bus.mul_z_ack) begin z_done = 1; z_cyc = cyc; end
            if (bus.out_valid && bus.out_ready) o_done = 1;
            step();
            cyc++;
        end
        bus.mul_a_ack = 1'b0; bus.mul_b_ack = 1'b0; bus.mul_z_stb = 1'b0; bus.out_ready = 1'b0;
        check("op_done", 32'(o_done), 32'd1);
        check("a_xfers", 32'(a_x), 32'd1);
        check("b_xfers", 32'(b_x), 32'd1);
        check("zack_cycle", 32'(zack_cyc), 32'(v.exp_zack));
        check("z_to_valid", 32'(ov_cyc - z_cyc), 32'd1);
        check("out_valid_drop", 32'(bus.out_valid), 32'd0);
        check("op_count_inc", 32'(op_count), 32'(c0 + 16'd1));
        check("in_ready_back", 32'(bus.in_ready), 32'd1);
        check("no_accept_on_out", 32'(bus.mul_a_stb), 32'd0);
    endtask

    initial begin
        // a, b, tag, z, a_dly, b_dly, z_dly, r_dly, hold, exp_zack
        vecs[0] = '{FP_TWO,       FP_THREE,     4'h5, 32'h40C00000, 1, 1, 1, 0, 1'b0, 2};
        vecs[1] = '{32'h3FC00000, 32'hC0000000, 4'hA, 32'hC0400000, 1, 2, 0, 0, 1'b1, 3};
        vecs[2] = '{32'h3F800000, 32'h3F800000, 4'h3, 32'h3F800000, 2, 6, 2, 0, 1'b0, 7};
        vecs[3] = '{32'h3F000000, 32'h40800000, 4'hC, 32'h40000000, 3, 1, 1, 5, 1'b0, 4};
        vecs[4] = '{32'h3FA00000, 32'h3FA00000, 4'hF, 32'h3FC80000, 1, 1, 3, 2, 1'b0, 2};
        vecs[5] = '{32'hBFC00000, 32'hBFC00000, 4'h0, 32'h40100000, 4, 4, 0, 0, 1'b0, 5};

        bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0; bus.in_valid = 1'b0;
        bus.mul_a_ack = 1'b0; bus.mul_b_ack = 1'b0; bus.mul_z = '0; bus.mul_z_stb = 1'b0;
        bus.out_ready = 1'b0; err_clr = 1'b0;
        rst = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_stbs", 32'({bus.mul_a_stb, bus.mul_b_stb, bus.mul_z_ack, bus.out_valid}), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_out_z", bus.out_z, 32'd0);

        for (int i = 0; i < 6; i++) run_op(vecs[i]);

        // Watchdog: operands accepted immediately, product withheld.
        cnt0 = op_count;
        bus.in_a = FP_TWO; bus.in_b = FP_THREE; bus.in_tag = 4'h9; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.mul_a_ack = 1'b1; bus.mul_b_ack = 1'b1;
        for (int c = 1; c <= int'(TIMEOUT); c++) begin
            check("wd_err_low", 32'(err), 32'd0);
            step();
        end
        check("wd_err_set", 32'(err), 32'd1);
        check("wd_zack_held", 32'(bus.mul_z_ack), 32'd1);
        step(); step();
        check("wd_err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("wd_err_clr", 32'(err), 32'd0);
        check("wd_zack_after_clr", 32'(bus.mul_z_ack), 32'd1);
        step();
        check("wd_no_retrigger", 32'(err), 32'd0);
        bus.mul_z = 32'h40C00000; bus.mul_z_stb = 1'b1;
        step();
        bus.mul_z_stb = 1'b0; bus.mul_a_ack = 1'b0; bus.mul_b_ack = 1'b0;
        check("wd_late_valid", 32'(bus.out_valid), 32'd1);
        check("wd_late_z", bus.out_z, 32'h40C00000);
        check("wd_late_tag", 32'(bus.out_tag), 32'h9);
        check("wd_late_zack", 32'(bus.mul_z_ack), 32'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("wd_op_count", 32'(op_count), 32'(cnt0 + 16'd1));
        check("wd_out_drop", 32'(bus.out_valid), 32'd0);

        // Timeout and err_clr on the same edge: set wins. Then reset in WAIT_Z.
        bus.in_a = 32'h3F800000; bus.in_b = FP_TWO; bus.in_tag = 4'h6; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.mul_a_ack = 1'b1; bus.mul_b_ack = 1'b1;
        for (int c = 1; c < int'(TIMEOUT); c++) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("sw_set_wins", 32'(err), 32'd1);
        check("sw_in_wait_z", 32'(bus.mul_z_ack), 32'd1);
        check("pre_rst_count", 32'(op_count), 32'd7);
        rst = 1'b0;
        step();
        rst = 1'b1; bus.mul_a_ack = 1'b0; bus.mul_b_ack = 1'b0;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_stbs", 32'({bus.mul_a_stb, bus.mul_b_stb, bus.mul_z_ack, bus.out_valid}), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        check("mid_rst_mul_a", bus.mul_a, 32'd0);
        check("mid_rst_mul_b", bus.mul_b, 32'd0);
        check("mid_rst_out_z", bus.out_z, 32'd0);
        check("mid_rst_out_tag", 32'(bus.out_tag), 32'd0);

        run_op(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_mul_driver.md
Name: fp_mul_driver

Overview:
Initiator for the single-precision multiplier's stb/ack operand and result handshake. Accepts tagged operand pairs from an upstream valid/ready stream and drives operands A and B to the multiplier. Collects the product and presents it, with its tag, on a downstream valid/ready stream. Sits between the block-matrix scheduler and each multiplier instance, one operation in flight at a time, with a watchdog and status counters.

Parameters:
TAG_W, 4, width of the operation tag carried alongside operands and result
TIMEOUT_CYCLES, 1024, cycles spent in SEND plus WAIT_Z before err asserts
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (reset when rst==0 at clk edge)
in_a  in  32  operand A, IEEE-754 single
in_b  in  32  operand B, IEEE-754 single
in_tag  in  TAG_W  operation tag
in_valid  in  1  upstream pair valid
in_ready  out  1  high only in IDLE (combinational from state)
mul_a  out  32  operand A to multiplier
mul_a_stb  out  1  operand A strobe
mul_a_ack  in  1  multiplier accepts A
mul_b  out  32  operand B to multiplier
mul_b_stb  out  1  operand B strobe
mul_b_ack  in  1  multiplier accepts B
mul_z  in  32  product from multiplier
mul_z_stb  in  1  product strobe
mul_z_ack  out  1  driver accepts product
out_z  out  32  product to downstream
out_tag  out  TAG_W  tag of out_z
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
err  out  1  sticky watchdog flag
err_clr  in  1  clears err
op_count  out  CNT_W  completed downstream transfers, wraps

Behaviour:
- Transfer rule on every stb/ack pair: a transfer occurs on a clk edge where stb and ack are both 1.
- All outputs except in_ready are registered.
- Reset values: mul_a_stb, mul_b_stb, mul_z_ack, out_valid, err = 0; op_count = 0; mul_a, mul_b, out_z = 0; out_tag = 0; state = IDLE.
- Reset mid-operation aborts silently. The multiplier is reset by the same rst net.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a→mul_a, in_b→mul_b, in_tag→tag register.
  - Set mul_a_stb=1 and mul_b_stb=1; clear the watchdog counter; go to SEND.
- SEND:
  - A and B complete independently. On the A transfer edge, mul_a_stb<=0 on that same edge; likewise B.
  - The multiplier re-raises ack the next cycle, so a strobe must never remain high after its transfer edge. Re-accepting an operand is a protocol violation.
  - Acks may arrive in either order or on the same edge.
  - When both transfers are done (including both on the current edge), set mul_z_ack<=1 and go to WAIT_Z.
  - mul_a and mul_b stay stable while SEND is active.
- WAIT_Z:
  - On the mul_z_stb && mul_z_ack edge: capture mul_z→out_z and tag→out_tag; mul_z_ack<=0; out_valid<=1; go to OUT.
  - mul_z_ack is never high outside WAIT_Z.
- OUT:
  - out_z and out_tag stay stable while out_valid=1 && out_ready=0.
  - On the out_valid && out_ready edge: out_valid<=0; op_count<=op_count+1 (wraps modulo 2^CNT_W); go to IDLE.
  - No new pair is accepted on that same edge. Issue rate is at most one operation per (handshake latency + 2) cycles.
- Latency: out_valid rises the cycle after the mul_z transfer edge. Minimum in_valid-accept to out_valid is multiplier latency + 3 cycles.
- Watchdog:
  - Counter increments each cycle in SEND or WAIT_Z and saturates.
  - When it reaches TIMEOUT_CYCLES, err<=1. The FSM keeps waiting and never drops a pending handshake.
  - err_clr=1 clears err on the next edge. If the timeout hit and err_clr land on the same edge, set wins.
  - The counter clears on entry to SEND.

Decomposition:
- Shared package holds:
  - state encoding IDLE=2'd0, SEND=2'd1, WAIT_Z=2'd2, OUT=2'd3;
  - default TAG_W and CNT_W;
  - FP constants reused by benches: 2.0=32'h40000000, 3.0=32'h40400000.
- One sub-module, handshake_watchdog: saturating counter with clear, enable, and hit output, parameterised by TIMEOUT_CYCLES. Reused by other stb/ack initiators.

Test Plan:
- Real multiplier, a=32'h40000000 (2.0), b=32'h40400000 (3.0), tag=4'h5 → out_z=32'h40C00000, out_tag=4'h5, op_count=1, each stb high for exactly one transfer.
- a=32'h3FC00000 (1.5), b=32'hC0000000 (−2.0) → out_z=32'hC0400000. Back-to-back second pair accepted only after out transfer.
- Stub multiplier: mul_a_ack pulses cycle 2, mul_b_ack cycle 6 after SEND entry → mul_a_stb low from cycle 3, mul_b_stb high through cycle 6, mul_z_ack rises cycle 7.
- out_ready held 0 for 5 cycles after out_valid → out_z/out_tag stable, in_ready=0, op_count unchanged until the release edge.
- TIMEOUT_CYCLES=16, stub never asserts mul_z_stb → err=1 after 16 SEND+WAIT_Z cycles, mul_z_ack stays 1. Pulse err_clr → err=0 next edge. Late mul_z_stb still completes the operation.
- rst=0 for one edge while in WAIT_Z → all outputs return to reset values, state IDLE, in_ready=1 next cycle.
